// File: rtl/digit_serial_subtractor.sv
// Digit-serial a - b - bin over WIDTH bits, DIGIT bits per clock, with a borrow
// chained through a register, signed-overflow detection and optional saturation.
module digit_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state_q is the FSM observation point for checkers bound to this block.
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, sat_q, a_msb, b_msb, bout_q, ovf_q;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next, sat_val;
  logic             last_digit, ovf_next, accept;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid are functions of state only, and a producer must
  // hold its payload stable until the transfer edge.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign accept    = in_valid & in_ready;

  assign dsum       = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, borrow_q};
  assign res_next   = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign last_digit = (cnt_q == CW'(N - 1));
  assign ovf_next   = (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
  assign sat_val    = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      sat_q    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow_q <= bin;
            sat_q    <= sat;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            cnt_q    <= '0;
          end
        end
        RUN: begin
          borrow_q <= dsum[DIGIT];
          a_sh     <= a_sh >> DIGIT;
          b_sh     <= b_sh >> DIGIT;
          res_q    <= res_next;
          cnt_q    <= cnt_q + CW'(1);
          // Result outputs are loaded only on the final digit, i.e. on DONE entry.
          if (last_digit) begin
            diff_q <= (sat_q & ovf_next) ? sat_val : res_next;
            bout_q <= dsum[DIGIT];
            ovf_q  <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
